// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The misaligned-fetch trap is enabled by defining IFU_MISALIGN_TRAP_EN.
package ifu_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int          FETCH_QUEUE_DEPTH = 2;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    // Sequential successor; the 32-bit add wraps 0xFFFF_FFFC to 0.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// Two-entry in-order fetch queue between the memory side and decode.
// flush dominates push/pop; push with pop is legal while full.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    logic [1:0]   count_q;
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    fetch_entry_t slots_q [2];

    logic do_push;
    logic do_pop;
    logic last_pop;

    assign empty    = (count_q == 2'd0);
    assign full     = (count_q == 2'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Popping the only entry parks the read pointer so the head keeps its last value.
    assign last_pop = do_pop && !do_push && (count_q == 2'd1);
    assign head     = slots_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            // NOTE: storage is reset on purpose so the head reads all-zero out of reset.
            for (int i = 0; i < 2; i++) begin
                slots_q[i] <= '0;
            end
        end else if (flush) begin
            count_q  <= 2'd0;
            wr_ptr_q <= rd_ptr_q;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            if (do_push) begin
                slots_q[wr_ptr_q] <= push_entry;
                wr_ptr_q          <= !wr_ptr_q;
            end else if (last_pop) begin
                wr_ptr_q <= rd_ptr_q;
            end

            if (do_pop && !last_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end

            if (do_push && !do_pop) begin
                count_q <= count_q + 2'd1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory and feeds decode.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault,
    input  logic        id_ready
);

    logic [31:0]  pc_q;
    logic [31:0]  pc_load;
    logic         deq;
    logic         issue;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign if_valid  = !q_empty;
    // A head shown during a redirect is wrong-path and never counts as accepted.
    assign deq       = if_valid && id_ready && !redirect_valid;
    assign imem_addr = pc_q;
    assign imem_req  = issue;

`ifdef IFU_MISALIGN_TRAP_EN
    logic halted_q;

    assign issue   = fetch_en && !halted_q && !redirect_valid && (!q_full || deq);
    assign pc_load = redirect_pc;

    always_comb begin
        // NOTE: default first so every path assigns push_entry and no latch is inferred.
        push_entry = '{pc: pc_q, instr: imem_rdata, fault: 1'b0};
        if (is_misaligned(pc_q)) begin
            push_entry = '{pc: pc_q, instr: NOP_INSTR, fault: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (issue && is_misaligned(pc_q)) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign issue   = fetch_en && !redirect_valid && (!q_full || deq);
    assign pc_load = align_pc(redirect_pc);

    always_comb begin
        push_entry = '{pc: pc_q, instr: imem_rdata, fault: 1'b0};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= pc_load;
        end else if (issue) begin
            pc_q <= next_pc(pc_q);
        end
    end

    ifu_fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (issue),
        .push_entry(push_entry),
        .pop       (deq),
        .head      (head_entry),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Without the trap nothing is ever pushed with fault set, so this is constant zero.
    assign if_pc    = head_entry.pc;
    assign if_instr = head_entry.instr;
    assign if_fault = head_entry.fault;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the 5-stage pipeline: owns the program counter, drives the address side of the instruction memory, and delivers `{pc, instruction}` pairs to the decode stage over a valid/ready handshake. It sits between the instruction memory and the IF/ID boundary. A 2-entry fetch queue absorbs decode back-pressure so that no fetched word is lost. Branch/jump redirects from EX flush the queue and restart fetch at the target.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `QUEUE_DEPTH`, default `2`: fetch queue entries. Legal values are 2 only; the count width is fixed at 2 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  when low, no new fetches are issued; queued entries still drain.
- `imem_addr`  out  32  byte address presented to the instruction memory; always equals `pc_q`.
- `imem_req`  out  1  high in cycles where the returned word is captured.
- `imem_rdata`  in  32  instruction word. The memory is combinational, so this is valid in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  taken branch/jump from EX.
- `redirect_pc`  in  32  redirect target.
- `if_valid`  out  1  queue head valid.
- `if_pc`  out  32  PC of the queue head.
- `if_instr`  out  32  instruction of the queue head.
- `if_fault`  out  1  the queue head is a misaligned-fetch fault entry.
- `id_ready`  in  1  decode accepts the head this cycle.

## Operation
- **State**
  - `pc_q` holds the next fetch address.
  - The queue holds `{pc, instr, fault}` entries; `count_q` ranges 0..2.
  - `halted_q` is set only in the fault path.
- **Dequeue**
  - `deq = if_valid && id_ready && !redirect_valid`.
- **Issue**
  - `issue = fetch_en && !halted_q && !redirect_valid && (count_q < 2 || deq)`.
  - `imem_req = issue`.
  - On issue: push `{pc_q, imem_rdata, 0}` and set `pc_q <= pc_q + 4`. The add is 32-bit modulo; `32'hFFFF_FFFC` wraps to `0`.
- **Simultaneous push and dequeue**
  - `count_q` is unchanged; the head advances and the new entry is appended in order.
- **Redirect** (highest priority)
  - Queue is flushed: `count_q <= 0`.
  - `pc_q <= redirect_pc`.
  - `halted_q <= 0`.
  - No push that cycle.
  - Any head presented in that cycle is wrong-path. Decode must treat it as not accepted even if `id_ready` is high.
- **Outputs**
  - `if_valid = (count_q != 0)`.
  - `if_pc`, `if_instr` and `if_fault` come from the head entry.
  - When the queue is empty, `if_pc`/`if_instr` hold their last value and must not be sampled.
- **`fetch_en` low**
  - `pc_q` holds and the queue drains normally.
  - Re-raising `fetch_en` resumes fetch at `pc_q` with no gap.

## Timing
- Reset values:
  - `pc_q = RESET_PC`.
  - `count_q = 0`, `halted_q = 0`.
  - `if_valid = 0`, `if_fault = 0`, `if_pc = 0`, `if_instr = 0`.
  - `imem_addr = RESET_PC`.
- First fetch occurs in the first clock edge after `rst_n` deasserts; `if_valid` rises 1 cycle later.
- Fetch-to-decode latency is 1 cycle.
- Sustained throughput is 1 instruction/cycle while `id_ready` stays high.
- Redirect penalty: redirect in cycle N, target fetched in N+1, target visible on `if_*` in N+2.
- Full queue with `id_ready` low: `imem_req = 0`, `pc_q` holds, and the head stays stable until accepted.
- Reset asserted mid-operation clears all state immediately (asynchronously); in-flight entries are discarded.

## Configuration
- `IFU_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` loads `pc_q` unmodified.
  - The next issue pushes `{pc_q, NOP, 1}` instead of the memory word and sets `halted_q`.
  - While halted, no further fetch occurs until the next redirect or reset.
- Undefined:
  - `redirect_pc[1:0]` is forced to `2'b00` on load.
  - `if_fault` is tied to 0 and `halted_q` is removed.

## Structure
- Package `ifu_pkg` contains:
  - `NOP_INSTR = 32'h0000_0013`.
  - `DEFAULT_RESET_PC`.
  - `typedef struct packed { logic [31:0] pc; logic [31:0] instr; logic fault; } fetch_entry_t`.
- Sub-module `ifu_fetch_queue`:
  - 2-entry FIFO of `fetch_entry_t` with `push`, `pop`, `flush`, `full` and `empty`.
  - `flush` dominates push and pop.
  - Simultaneous push and pop are legal when full.

## Test plan
- Reset with `RESET_PC = 0x100` and `id_ready = 1`, memory returns `0xA000_0000 + addr`.
  - Required: `if_pc` = 0x100, 0x104, 0x108 on consecutive cycles starting 1 cycle after reset release.
- Hold `id_ready = 0` for 5 cycles.
  - Required: `imem_req` drops after 2 pushes, the head stays at the same PC, and release delivers every PC in order with no duplicates.
- Redirect to `0x200` while the queue holds 2 entries.
  - Required: `if_valid` is 0 in the next cycle, then `if_pc = 0x200` two cycles after the redirect.
- Set `pc_q = 0xFFFF_FFFC`.
  - Required: the following fetch address is `0x0000_0000`.
- Redirect to `0x202`.
  - With macro: `if_fault = 1` and `if_instr = 0x13`, then no further `imem_req` until redirect to `0x300`, which resumes normally.
  - Without macro: fetch resumes at `0x200`.
- Assert `rst_n = 0` mid-stream with the queue full.
  - Required: `if_valid` deasserts immediately (asynchronously) and `imem_addr = RESET_PC`.
